// File: rtl/signed_dot_accum_if.sv
// Valid/ready stream bundle for signed_dot_accum:
// a 32-bit product stream in, and a 32-bit result stream with overflow out.
interface signed_dot_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_product;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_overflow;

  modport master (
    output in_valid,
    output in_product,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_overflow
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_overflow
  );
endinterface

// File: rtl/signed_dot_accum.sv
// Streaming signed dot-product accumulator over groups of LEN products.
// Define SIGNED_DOT_ACCUM_SAT_EN to saturate out_sum; default wraps to 32 bits.
module signed_dot_accum #(
  parameter int LEN   = 16,
  parameter int ACC_W = 40
) (
  input logic              clk,
  input logic              rst_n,
  signed_dot_accum_if.slave io_bus
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic [31:0]             r_out_sum;
  logic                    r_out_ovf;

  logic                    w_last;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_release;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic [ACC_W-32:0]       w_top;
  logic                    w_ovf;
  logic [31:0]             w_conv;

  assign w_last = (r_cnt == LAST);

  // Only the closing product of a group can stall, and only on a full output.
  assign w_in_ready = rst_n &&
    !(w_last && r_out_valid && !io_bus.out_ready);

  assign w_accept  = io_bus.in_valid && w_in_ready;
  assign w_release = r_out_valid && io_bus.out_ready;

  assign w_ext = {{(ACC_W-32){io_bus.in_product[31]}},
                  io_bus.in_product};
  assign w_sum = r_acc + w_ext;

  // In range iff bits [ACC_W-1:31] are all copies of the sign.
  assign w_top = w_sum[ACC_W-1:31];
  assign w_ovf = !((&w_top) || !(|w_top));

`ifdef SIGNED_DOT_ACCUM_SAT_EN
  always_comb begin
    w_conv = w_sum[31:0];
    if (w_ovf) begin
      w_conv = w_sum[ACC_W-1] ? 32'h8000_0000
                              : 32'h7FFF_FFFF;
    end
  end
`else
  assign w_conv = w_sum[31:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_accept && w_last) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_conv;
        r_out_ovf   <= w_ovf;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.out_valid    = r_out_valid;
  assign io_bus.out_sum      = r_out_sum;
  assign io_bus.out_overflow = r_out_ovf;

endmodule

// File: tb/tb_signed_dot_accum.sv
// Self-checking bench: table vectors, hand sequences and a random
// stream against a group-sum reference model, LEN=4 and LEN=1.
module tb_signed_dot_accum;

  localparam int LEN = 4;

  logic clk;
  logic rst_n;

  signed_dot_accum_if bus ();
  signed_dot_accum_if bus1 ();

  signed_dot_accum #(.LEN(LEN), .ACC_W(40)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  signed_dot_accum #(.LEN(1), .ACC_W(40)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] p [4];
    logic [31:0] sum;
    logic        ovf;
  } vec_t;

  int n_chk;
  int n_fail;

  res_t   q[$];
  longint gsum;
  int     gcnt;
  logic   last_rdy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic res_t model_out(input longint s);
    res_t r;
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef SIGNED_DOT_ACCUM_SAT_EN
    if (r.ovf) r.sum = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else       r.sum = 32'(s);
`else
    r.sum = 32'(s);
`endif
    return r;
  endfunction

  function automatic void model_clear();
    gsum = 0;
    gcnt = 0;
    q.delete();
  endfunction

  // One clock of the LEN=4 stream: drive, check, advance the model.
  task automatic cycle(input logic v, input logic [31:0] p,
                       input logic r);
    logic exp_rdy;
    res_t e;
    @(negedge clk);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    bus.in_valid   = v;
    bus.in_product = p;
    bus.out_ready  = r;
    #1;
    exp_rdy = !(gcnt == LEN - 1 && q.size() != 0 && !r);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    last_rdy = bus.in_ready;
    if (q.size() != 0 && r) begin
      e = q.pop_front();
      chk("out_sum", bus.out_sum, e.sum);
      chk("out_overflow", {31'd0, bus.out_overflow}, {31'd0, e.ovf});
    end
    if (v && exp_rdy) begin
      gsum += longint'($signed(p));
      gcnt++;
      if (gcnt == LEN) begin
        q.push_back(model_out(gsum));
        gsum = 0;
        gcnt = 0;
      end
    end
  endtask

  task automatic peek(input string name, input logic [31:0] sum,
                      input logic ovf);
    @(posedge clk);
    #2;
    chk({name, " valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, " sum"}, bus.out_sum, sum);
    chk({name, " ovf"}, {31'd0, bus.out_overflow}, {31'd0, ovf});
  endtask

  vec_t vecs [5];

  initial begin
    logic [31:0] rp;
    n_chk  = 0;
    n_fail = 0;
    model_clear();

    vecs[0] = '{p: '{32'd1, 32'd2, 32'd3, 32'd4},
                sum: 32'd10, ovf: 1'b0};
    vecs[1] = '{p: '{32'h8000_0000, 32'h8000_0000,
                     32'h8000_0000, 32'h8000_0000},
`ifdef SIGNED_DOT_ACCUM_SAT_EN
                sum: 32'h8000_0000,
`else
                sum: 32'h0000_0000,
`endif
                ovf: 1'b1};
    vecs[2] = '{p: '{32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                     32'h8000_0001},
                sum: 32'd0, ovf: 1'b0};
    vecs[3] = '{p: '{32'h7FFF_FFFF, 32'h7FFF_FFFF,
                     32'h7FFF_FFFF, 32'h7FFF_FFFF},
`ifdef SIGNED_DOT_ACCUM_SAT_EN
                sum: 32'h7FFF_FFFF,
`else
                sum: 32'hFFFF_FFFC,
`endif
                ovf: 1'b1};
    vecs[4] = '{p: '{32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd7, 32'd100},
                sum: 32'd96, ovf: 1'b0};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_product  = '0;
    bus.out_ready   = 1'b1;
    bus1.in_valid   = 1'b0;
    bus1.in_product = '0;
    bus1.out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst out_sum", bus.out_sum, 32'd0);
    chk("rst out_ovf", {31'd0, bus.out_overflow}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) cycle(1'b1, vecs[i].p[k], 1'b1);
      peek($sformatf("vec%0d", i), vecs[i].sum, vecs[i].ovf);
    end
    cycle(1'b0, 32'd0, 1'b1);

    // Backpressure: pending result, three more accepted, final stalls.
    for (int k = 1; k <= 4; k++) cycle(1'b1, 32'(k), 1'b0);
    repeat (3) cycle(1'b1, 32'd5, 1'b0);
    cycle(1'b1, 32'd5, 1'b0);
    chk("stall in_ready", {31'd0, last_rdy}, 32'd0);
    chk("stall hold sum", bus.out_sum, 32'd10);
    cycle(1'b1, 32'd5, 1'b1);
    chk("drain in_ready", {31'd0, last_rdy}, 32'd1);
    peek("drain", 32'd20, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);

    // Random stream with bubbles and random backpressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rp = $urandom;
      else rp = 32'($signed($urandom_range(0, 200)) - 100);
      cycle($urandom_range(0, 2) != 0, rp, $urandom_range(0, 3) != 0);
    end
    repeat (2) cycle(1'b0, 32'd0, 1'b1);

    // Reset mid-group with a result pending.
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd1, 1'b0);
    repeat (2) cycle(1'b1, 32'd9, 1'b0);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid-rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid-rst out_sum", bus.out_sum, 32'd0);
    chk("mid-rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid-rst release rdy", {31'd0, bus.in_ready}, 32'd1);
    model_clear();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd7, 1'b1);
    peek("after rst", 32'd28, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);

    // LEN=1: every product is its own result.
    @(negedge clk);
    bus1.in_valid   = 1'b1;
    bus1.in_product = 32'd3;
    @(negedge clk);
    chk("len1 valid0", {31'd0, bus1.out_valid}, 32'd1);
    chk("len1 sum0", bus1.out_sum, 32'd3);
    bus1.in_product = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("len1 valid1", {31'd0, bus1.out_valid}, 32'd1);
    chk("len1 sum1", bus1.out_sum, 32'hFFFF_FFFD);
    chk("len1 ovf1", {31'd0, bus1.out_overflow}, 32'd0);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("len1 idle", {31'd0, bus1.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
